keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving columns and sampling rows.
- Debounces one key at a time and emits the key's hex code with a single-cycle strobe.
- It is the input-side counterpart to the shift-register / multiplexed seven-segment display path: its value/trig outputs feed the shift register's in/trig.

Parameters:
- CLK_DIV, 50000: clk cycles per scan tick (1 kHz at 50 MHz). Legal range is CLK_DIV >= 4.
- DEBOUNCE, 4: number of consecutive stable scan ticks required to accept a press or a release. Legal range is DEBOUNCE >= 1.

Ports:
- clk  in  1  system clock (50 MHz); the single clock domain.
- reset  in  1  synchronous, active-high reset.
- row  in  4  keypad rows, active-low (pulled up), asynchronous; row[0] is the top row.
- col  out  4  keypad column drive, one-hot active-low; col[0] is the leftmost column.
- value  out  4  hex code of the last accepted key.
- trig  out  1  one-cycle strobe; value is valid in the same cycle.
- key_down  out  1  high while an accepted key is held.

Behaviour:
- Reset values: col=4'b1110, value=0, trig=0, key_down=0, state=SCAN, column index=0, tick counter=0, debounce counter=0.
- Input synchronisation: row passes through a 2-flop synchroniser; all decisions use the synchronised row (rs).
- Tick generation: counter runs 0..CLK_DIV-1; tick is high for one cycle when count==CLK_DIV-1, then the counter wraps to 0. State is evaluated only on tick cycles.
- Key map (row,col) -> code:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- SCAN:
  - col = ~(1<<idx).
  - On tick with rs==4'hF: idx = (idx+1) mod 4. Wrap 3->0.
  - On tick with rs!=4'hF: latch idx and rs pattern, set cnt=1, go to DEBOUNCE. col stays on the current column.
  - If several rows are low, the lowest-index low row selects the key.
- DEBOUNCE:
  - On tick with rs equal to the latched pattern: cnt++.
  - When cnt reaches DEBOUNCE, go to HELD. On that same edge: value<=code, trig<=1, key_down<=1.
  - On tick with rs different from the latched pattern: no trig, idx advances, go to SCAN.
  - With DEBOUNCE=1 the press is accepted at the first tick that sees it (go directly to HELD).
- HELD:
  - col stays fixed; no auto-repeat.
  - On tick with rs==4'hF: cnt=1, go to RELEASE.
  - Any other rs keeps HELD. Extra keys pressed are ignored.
- RELEASE:
  - On tick with rs==4'hF: cnt++.
  - When cnt reaches DEBOUNCE: key_down<=0, idx advances, go to SCAN.
  - On tick with rs!=4'hF: go back to HELD with no new trig.
- trig is high for exactly one clk cycle per accepted press, and deasserts the cycle after it is set.
- Latency: from the row edge to trig is at most 2 sync cycles + (DEBOUNCE+4)*CLK_DIV cycles (worst case includes one full column sweep).
- Reset mid-operation in any state: all outputs return to their reset values on the next edge. trig is never emitted from a partially debounced press.
- value holds its last code until the next accepted press; it is not cleared on release.

Test Plan:
- Bench settings: CLK_DIV=4, DEBOUNCE=3. The keypad model pulls row[r] low while col[c] is low and key (r,c) is pressed.
- Reset, no keys -> col=1110; after one tick 1101, then 1011, then 0111, then 1110 (wrap). trig=0, value=0, key_down=0 throughout.
- Press key (1,1) and hold for 50 ticks -> exactly one trig pulse with value=5, key_down=1. col frozen at 1101 while held. No further trig.
- Release after the previous case -> key_down falls after 3 released ticks. Scanning resumes: next col=1011. value stays 5.
- Bounce: press (0,3) for 1 tick, then release -> no trig, value unchanged, scanning continues.
- Sequential presses (3,0), (3,2), (3,3), (3,1) with full releases between -> trig values E, F, D, 0. Each press yields one trig.
- Hold (2,0) to HELD, assert reset for 1 cycle -> next cycle col=1110, key_down=0, trig=0, value=0. The still-held key is re-accepted later as value=7 with a single trig.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick,
// debounces a single key and strobes its hex code out on value/trig.
module keypad_scanner #(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] value,
    output logic       trig,
    output logic       key_down
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        rs_meta, rs;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [1:0]        idx, idx_nx;
    logic [3:0]        pat, pat_nx;
    logic [DB_W-1:0]   dcnt, dcnt_nx, dcnt_inc;
    logic [3:0]        value_nx;
    logic              trig_nx, key_down_nx;

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [3:0] key_code(input logic [3:0] pattern, input logic [1:0] c);
        logic [1:0] r;
        if (!pattern[0])      r = 2'd0;
        else if (!pattern[1]) r = 2'd1;
        else if (!pattern[2]) r = 2'd2;
        else                  r = 2'd3;
        case ({r, c})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hE;
            4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign col      = ~(4'b0001 << idx);
    assign dcnt_inc = dcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_meta  <= 4'hF;
            rs       <= 4'hF;
            div_cnt  <= '0;
            state    <= S_SCAN;
            idx      <= 2'd0;
            pat      <= 4'hF;
            dcnt     <= '0;
            value    <= 4'h0;
            trig     <= 1'b0;
            key_down <= 1'b0;
        end else begin
            rs_meta  <= row;
            rs       <= rs_meta;
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            state    <= state_nx;
            idx      <= idx_nx;
            pat      <= pat_nx;
            dcnt     <= dcnt_nx;
            value    <= value_nx;
            trig     <= trig_nx;
            key_down <= key_down_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        pat_nx      = pat;
        dcnt_nx     = dcnt;
        value_nx    = value;
        trig_nx     = 1'b0;
        key_down_nx = key_down;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (rs == 4'hF) begin
                        idx_nx = idx + 2'd1;
                    end else begin
                        pat_nx  = rs;
                        dcnt_nx = DB_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_nx    = S_HELD;
                            value_nx    = key_code(rs, idx);
                            trig_nx     = 1'b1;
                            key_down_nx = 1'b1;
                        end else begin
                            state_nx = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (rs == pat) begin
                        dcnt_nx = dcnt_inc;
                        if (dcnt_inc == DB_W'(DEBOUNCE)) begin
                            state_nx    = S_HELD;
                            value_nx    = key_code(pat, idx);
                            trig_nx     = 1'b1;
                            key_down_nx = 1'b1;
                        end
                    end else begin
                        idx_nx   = idx + 2'd1;
                        state_nx = S_SCAN;
                    end
                end
                S_HELD: begin
                    // Column stays parked on the held key; other keys are ignored.
                    if (rs == 4'hF) begin
                        dcnt_nx = DB_W'(1);
                        if (DEBOUNCE == 1) begin
                            key_down_nx = 1'b0;
                            idx_nx      = idx + 2'd1;
                            state_nx    = S_SCAN;
                        end else begin
                            state_nx = S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (rs == 4'hF) begin
                        dcnt_nx = dcnt_inc;
                        if (dcnt_inc == DB_W'(DEBOUNCE)) begin
                            key_down_nx = 1'b0;
                            idx_nx      = idx + 2'd1;
                            state_nx    = S_SCAN;
                        end
                    end else begin
                        state_nx = S_HELD;
                    end
                end
                default: state_nx = S_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed bench for keypad_scanner against a tick-level key model.
module tb_keypad_scanner;

    localparam int CLK_DIV  = 4;
    localparam int DB       = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] value;
    logic       trig;
    logic       key_down;

    logic [3:0][3:0] keys;   // keys[r][c] = 1 while key (r,c) is pressed

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DB)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .value(value), .trig(trig), .key_down(key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~(|(keys[r] & ~col));
    end

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    // Model: 0 scanning, 1 confirming press, 2 held, 3 confirming release
    int         m_phase, m_col, m_stable, div;
    logic [3:0] m_pat, m_value;
    logic       m_down, m_trig;
    int         vectors = 0, errs = 0, trig_seen = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_stable = 0; m_pat = 4'hF;
        m_value = 4'h0; m_down = 1'b0; m_trig = 1'b0; div = 0;
    endtask

    task automatic accept();
        int r;
        r = 3;
        for (int k = 3; k >= 0; k--) if (!m_pat[k]) r = k;
        m_value = keymap[r*4 + m_col];
        m_trig  = 1'b1;
        m_down  = 1'b1;
        m_phase = 2;
    endtask

    task automatic release_key();
        m_down  = 1'b0;
        m_col   = (m_col + 1) % 4;
        m_phase = 0;
    endtask

    task automatic model_tick();
        logic [3:0] seen;
        for (int r = 0; r < 4; r++) seen[r] = !keys[r][m_col];
        case (m_phase)
            0: if (seen == 4'hF) m_col = (m_col + 1) % 4;
               else begin
                   m_pat = seen; m_stable = 1; m_phase = 1;
                   if (m_stable >= DB) accept();
               end
            1: if (seen == m_pat) begin
                   m_stable++;
                   if (m_stable == DB) accept();
               end else begin
                   m_phase = 0; m_col = (m_col + 1) % 4;
               end
            2: if (seen == 4'hF) begin
                   m_stable = 1; m_phase = 3;
                   if (m_stable >= DB) release_key();
               end
            default: if (seen == 4'hF) begin
                   m_stable++;
                   if (m_stable == DB) release_key();
               end else m_phase = 2;
        endcase
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic cyc();
        logic [3:0] ecol;
        @(posedge clk);
        m_trig = 1'b0;
        if (reset) model_reset();
        else if (div == CLK_DIV - 1) begin div = 0; model_tick(); end
        else div++;
        @(negedge clk);
        ecol = 4'hF;
        ecol[m_col] = 1'b0;
        chk("col", col, ecol);
        chk("value", value, m_value);
        chk("trig", {3'b0, trig}, {3'b0, m_trig});
        chk("key_down", {3'b0, key_down}, {3'b0, m_down});
        if (trig === 1'b1) trig_seen++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * CLK_DIV) cyc();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic press(input int r, input int c);
        keys[r][c] = 1'b1;
    endtask

    logic [3:0] seq_codes [4] = '{4'hE, 4'hF, 4'hD, 4'h0};
    int         seq_r [4] = '{3, 3, 3, 3};
    int         seq_c [4] = '{0, 2, 3, 1};

    initial begin
        keys = '0;
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
        run_ticks(6);

        // Long hold of key 5: exactly one strobe, column parked
        press(1, 1);
        trig_seen = 0;
        run_ticks(50);
        chk("hold_trigs", 4'(trig_seen), 4'd1);
        chk("hold_value", value, 4'h5);
        chk("hold_col", col, 4'b1101);
        keys = '0;
        run_ticks(6);
        chk("rel_value", value, 4'h5);

        // One-tick bounce on key A while its column is driven
        while (m_col != 3) run_ticks(1);
        trig_seen = 0;
        press(0, 3);
        run_ticks(1);
        keys = '0;
        run_ticks(6);
        chk("bounce_trigs", 4'(trig_seen), 4'd0);

        for (int i = 0; i < 4; i++) begin
            trig_seen = 0;
            press(seq_r[i], seq_c[i]);
            run_ticks(12);
            keys = '0;
            run_ticks(8);
            chk("seq_trigs", 4'(trig_seen), 4'd1);
            chk("seq_value", value, seq_codes[i]);
        end

        // Reset while holding key 7, then re-acceptance
        press(2, 0);
        run_ticks(12);
        chk("pre_rst_down", {3'b0, key_down}, 4'd1);
        pulse_reset();
        chk("rst_col", col, 4'b1110);
        chk("rst_value", value, 4'h0);
        trig_seen = 0;
        run_ticks(12);
        chk("rehold_trigs", 4'(trig_seen), 4'd1);
        chk("rehold_value", value, 4'h7);
        keys = '0;
        run_ticks(8);

        for (int i = 0; i < 40; i++) begin
            keys = '0;
            press($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) press($urandom_range(0, 3), $urandom_range(0, 3));
            run_ticks($urandom_range(1, 10));
            if ($urandom_range(0, 7) == 0) pulse_reset();
            keys = '0;
            run_ticks($urandom_range(1, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
